// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared memory size encodings, LSU FSM states and access legality check
package load_store_unit_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} lsu_state_t;
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_WORD) ? (off != 2'b00) :
           (size == SIZE_HALF) ? off[0] :
           (size != SIZE_BYTE);
  endfunction
endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: big-endian lane extraction and sign/zero extension of a loaded word
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] val
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = (offset == 2'd0) ? word[31:24] :
        (offset == 2'd1) ? word[23:16] :
        (offset == 2'd2) ? word[15:8] : word[7:0];
    h = offset[1] ? word[15:0] : word[31:16];
    val = (size == SIZE_WORD) ? word :
          (size == SIZE_HALF) ? {{16{sgn & h[15]}}, h} :
          {{24{sgn & b[7]}}, b};
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM between pipeline and big-endian data memory
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_tag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_tag,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_wscope,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  lsu_state_t  state_q, state_d;
  logic        we_q, we_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [4:0]  tag_q, tag_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]  resp_tag_q, resp_tag_d;
  logic        mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_wscope_q, mem_wscope_d;
  logic [31:0] ld_val;
  load_align u_align (.word(mem_rdata), .offset(off_q), .size(size_q), .sgn(sgn_q), .val(ld_val));
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wscope = mem_wscope_q;
  assign mem_wdata  = mem_wdata_q;
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    sgn_d        = sgn_q;
    err_d        = err_q;
    size_d       = size_q;
    off_d        = off_q;
    tag_d        = tag_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    resp_tag_d   = resp_tag_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wscope_d = '0;
    mem_wdata_d  = '0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d      = S_ISSUE;
        we_d         = req_we;
        sgn_d        = req_signed;
        size_d       = req_size;
        off_d        = req_addr[1:0];
        tag_d        = req_tag;
        err_d        = access_err(req_size, req_addr[1:0]);
        mem_en_d     = !err_d;
        mem_wr_d     = !err_d && req_we;
        mem_addr_d   = err_d ? '0 : req_addr;
        mem_wscope_d = err_d ? '0 : req_size;
        mem_wdata_d  = err_d ? '0 : req_wdata;
      end
      S_ISSUE: begin
        state_d      = (we_q || err_q) ? S_RESP : S_CAPTURE;
        resp_valid_d = we_q || err_q;
        resp_err_d   = err_q;
        resp_rdata_d = '0;
        resp_tag_d   = tag_q;
      end
      S_CAPTURE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = ld_val;
        resp_tag_d   = tag_q;
      end
      default: if (resp_ready) begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wscope_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      sgn_q        <= sgn_d;
      err_q        <= err_d;
      size_q       <= size_d;
      off_q        <= off_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q   <= resp_tag_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wscope_q <= mem_wscope_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with big-endian memory model for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_tag = '0;
  logic        req_ready, resp_valid, resp_err, mem_en, mem_wr;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  resp_tag;
  logic [1:0]  mem_wscope;
  typedef struct packed {logic [31:0] rdata; logic [4:0] tag; logic err;} exp_t;
  exp_t        sb[$];
  exp_t        got;
  int          errors = 0, checks = 0, en_n = 0;
  logic        seen = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] last_addr = '0, last_wdata = '0, w;
  logic [1:0]  last_scope = '0;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wscope(mem_wscope), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    if (mem_en) begin
      en_n++;
      last_addr = mem_addr;
      last_wdata = mem_wdata;
      last_scope = mem_wscope;
      if (mem_wr) begin
        w = mem[mem_addr[9:2]];
        if (mem_wscope == SIZE_WORD) w = mem_wdata;
        else if (mem_wscope == SIZE_HALF) begin
          if (mem_addr[1]) w[15:0] = mem_wdata[15:0];
          else w[31:16] = mem_wdata[15:0];
        end else w[8*(3-int'(mem_addr[1:0])) +: 8] = mem_wdata[7:0];
        mem[mem_addr[9:2]] = w;
      end else mem_rdata <= mem[mem_addr[9:2]];
    end
  end
  always @(negedge clk) begin
    if (resp_valid && !seen) begin
      seen = 1'b1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got resp rdata=%h tag=%0d err=%b, none expected", resp_rdata, resp_tag, resp_err);
      end else begin
        got = sb.pop_front();
        if ({resp_rdata, resp_tag, resp_err} !== got) begin
          errors++;
          $display("FAIL sb_resp: got rdata=%h tag=%0d err=%b, want rdata=%h tag=%0d err=%b",
                   resp_rdata, resp_tag, resp_err, got.rdata, got.tag, got.err);
        end
      end
    end else if (!resp_valid) seen = 1'b0;
  end
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] tag, input logic [31:0] exp_rdata,
                        input logic exp_err, output int lat, output int ens);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_tag = tag;
    sb.push_back('{exp_rdata, tag, exp_err});
    en_n = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    ens = en_n;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if ({resp_valid, resp_rdata, resp_tag, resp_err, mem_en, mem_wr, mem_addr, mem_wscope, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b rd=%h tag=%0d err=%b en=%b wr=%b addr=%h sc=%b wd=%h, want all 0",
               resp_valid, resp_rdata, resp_tag, resp_err, mem_en, mem_wr, mem_addr, mem_wscope, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_word();
    int lat, ens;
    do_req(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0, lat, ens);
    checks++;
    if (lat !== 2 || ens !== 1) begin errors++; $display("FAIL store_word_timing: got lat=%0d en=%0d want lat=2 en=1", lat, ens); end
    checks++;
    if ({last_addr, last_scope, last_wdata} !== {32'h100, SIZE_WORD, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL store_word_bus: got addr=%h sc=%b wd=%h want 100 11 deadbeef", last_addr, last_scope, last_wdata);
    end
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 5'd2, 32'hDEADBEEF, 1'b0, lat, ens);
    checks++;
    if (lat !== 3 || ens !== 1) begin errors++; $display("FAIL load_word_timing: got lat=%0d en=%0d want lat=3 en=1", lat, ens); end
  endtask
  task automatic test_subword();
    logic [1:0]  sz [5] = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_HALF, SIZE_BYTE};
    logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] ex [5] = '{32'hFFFFFFAD, 32'h000000EF, 32'hFFFFBEEF, 32'h0000DEAD, 32'hFFFFFFDE};
    int lat, ens;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sz[i], sg[i], ad[i], 32'hFFFFFFFF, 5'(i + 3), ex[i], 1'b0, lat, ens);
      checks++;
      if (lat !== 3 || ens !== 1) begin errors++; $display("FAIL subword_timing[%0d]: got lat=%0d en=%0d want lat=3 en=1", i, lat, ens); end
    end
  endtask
  task automatic test_store_half();
    int lat, ens;
    do_req(1'b1, SIZE_HALF, 1'b0, 32'h202, 32'hABCD1234, 5'd10, 32'h0, 1'b0, lat, ens);
    checks++;
    if (lat !== 2 || ens !== 1) begin errors++; $display("FAIL store_half_timing: got lat=%0d en=%0d want lat=2 en=1", lat, ens); end
    checks++;
    if ({last_addr, last_scope, last_wdata} !== {32'h202, SIZE_HALF, 32'hABCD1234}) begin
      errors++;
      $display("FAIL store_half_bus: got addr=%h sc=%b wd=%h want 202 01 abcd1234", last_addr, last_scope, last_wdata);
    end
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0, 5'd11, 32'h00001234, 1'b0, lat, ens);
    do_req(1'b1, SIZE_BYTE, 1'b0, 32'h201, 32'h000000A5, 5'd12, 32'h0, 1'b0, lat, ens);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0, 5'd13, 32'h00A51234, 1'b0, lat, ens);
  endtask
  task automatic test_errors();
    logic [1:0]  sz [3] = '{SIZE_WORD, SIZE_HALF, 2'b10};
    logic [31:0] ad [3] = '{32'h102, 32'h101, 32'h100};
    int lat, ens;
    for (int i = 0; i < 3; i++) begin
      do_req(i[0], sz[i], 1'b1, ad[i], 32'h55555555, 5'(i + 20), 32'h0, 1'b1, lat, ens);
      checks++;
      if (lat !== 2 || ens !== 0) begin errors++; $display("FAIL err_timing[%0d]: got lat=%0d en=%0d want lat=2 en=0", i, lat, ens); end
    end
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 5'd24, 32'hDEADBEEF, 1'b0, lat, ens);
  endtask
  task automatic test_backpressure();
    logic [37:0] snap;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h100; req_tag = 5'd7;
    sb.push_back('{32'hDEADBEEF, 5'd7, 1'b0});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    en_n = 0;
    snap = {resp_rdata, resp_tag, resp_err};
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h0; req_tag = 5'(i);
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_rdata, resp_tag, resp_err} !== {1'b1, 1'b0, snap}) begin
        errors++;
        $display("FAIL hold[%0d]: got rv=%b rr=%b rd=%h tag=%0d err=%b want rv=1 rr=0 %h", i,
                 resp_valid, req_ready, resp_rdata, resp_tag, resp_err, snap);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready, en_n} !== {1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL hold_release: got rv=%b rr=%b mem_en_cycles=%0d want rv=0 rr=1 0", resp_valid, req_ready, en_n);
    end
  endtask
  task automatic test_reset_mid();
    int lat, ens;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_addr = 32'h100; req_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    en_n = 0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_en} !== 3'b100) begin
      errors++;
      $display("FAIL rst_async: got rr=%b rv=%b en=%b want rr=1 rv=0 en=0", req_ready, resp_valid, mem_en);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, en_n} !== {1'b1, 1'b0, 32'd0}) begin
        errors++;
        $display("FAIL rst_discard[%0d]: got rr=%b rv=%b mem_en_cycles=%0d want rr=1 rv=0 0", i, req_ready, resp_valid, en_n);
      end
    end
    do_req(1'b0, SIZE_BYTE, 1'b0, 32'h102, 32'h0, 5'd30, 32'h000000BE, 1'b0, lat, ens);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rst_recover: got lat=%0d want 3", lat); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_word();
    test_subword();
    test_store_half();
    test_errors();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have pipeline request ports: req_valid in 1; req_ready out 1; req_we in 1 (1 store, 0 load); req_size in 2 (2'b11 word, 2'b01 half, 2'b00 byte); req_signed in 1 (load sign-extend); req_addr in 32; req_wdata in 32; req_tag in 5 (destination register).
REQ-003 SHALL have pipeline response ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32; resp_tag out 5; resp_err out 1 (misaligned or illegal size).
REQ-004 SHALL have data-memory ports: mem_en out 1; mem_wr out 1; mem_addr out 32; mem_wscope out 2; mem_wdata out 32; mem_rdata in 32 (big-endian aligned word, valid the cycle after a read issue).

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP; encoding in shared package.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a rising edge; all req_* fields latched then.
REQ-007 SHALL move IDLE->ISSUE on accept; in ISSUE drive mem_en=1, mem_wr=latched we, mem_addr=latched addr, mem_wscope=latched size, mem_wdata=latched wdata unshifted (memory takes byte from [7:0], half from [15:0]).
REQ-008 SHALL move ISSUE->RESP for stores (resp_rdata=0) and ISSUE->CAPTURE for loads; mem_en SHALL be 1 for exactly one cycle per legal access.
REQ-009 SHALL in CAPTURE register the extracted load data from mem_rdata and move to RESP; latency accept-to-resp_valid: store 2 cycles, load 3 cycles.
REQ-010 SHALL extract big-endian lanes by addr[1:0]: byte 0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0]; half 0->[31:16], 2->[15:0]; word -> [31:0].
REQ-011 SHALL sign-extend byte/half when req_signed=1, else zero-extend; word ignores req_signed.
REQ-012 SHALL flag error when size=word and addr[1:0]!=0, size=half and addr[0]=1, or size=2'b10; erroneous request SHALL go ISSUE->RESP with mem_en=0, resp_err=1, resp_rdata=0.
REQ-013 SHALL hold resp_valid, resp_rdata, resp_tag, resp_err stable in RESP until resp_ready=1; on that edge return to IDLE (no accept in the same cycle).
REQ-014 SHALL drive mem_en=0, mem_wr=0 and all other mem_* outputs 0 in every state except ISSUE.
REQ-015 SHALL ignore req_* fields while not in IDLE.

Reset
REQ-016 SHALL, while rst=1, force state IDLE asynchronously, regardless of any transfer in progress.
REQ-017 SHALL reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_tag=0, resp_err=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wscope=0, mem_wdata=0.
REQ-018 SHALL discard an in-flight request on reset with no response and no further memory access.

Structure
REQ-019 SHALL take size encodings (WORD=2'b11, HALF=2'b01, BYTE=2'b00) and FSM state constants from the shared memory-definitions package, also used by data_mem users.
REQ-020 SHALL place lane extraction and extension in one combinational sub-module load_align (inputs word, offset, size, signed; output 32-bit value).
REQ-021 SHALL register all outputs except req_ready, which decodes state directly.

Verification
REQ-022 Store word 0xDEADBEEF to 0x100, load word 0x100 -> resp_rdata=0xDEADBEEF, resp_err=0, load resp_valid 3 cycles after accept.
REQ-023 After REQ-022, load byte signed 0x101 -> 0xFFFFFFAD; unsigned 0x103 -> 0x000000EF; half signed 0x102 -> 0xFFFFBEEF.
REQ-024 Store half 0x1234 to 0x202, load word 0x200 -> low 16 bits 0x1234; mem_wscope=2'b01 and mem_en high exactly one cycle.
REQ-025 Load word 0x102 -> resp_err=1, resp_rdata=0, mem_en never asserted, resp_valid 2 cycles after accept.
REQ-026 Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, new req_valid ignored; assert rst during CAPTURE -> resp_valid stays 0, req_ready=1 after reset.
